// File: rtl/text_buffer.sv
// Character-cell text buffer with cursor, scrolling top-row pointer and registered logical reads.
// Optional blinking cursor overlay is compiled in with TEXT_BUFFER_CURSOR_EN.
module text_buffer #(
   parameter int COLS         = 70,
   parameter int ROWS         = 30,
   parameter int BLINK_CYCLES = 25000000,
   localparam int XW          = $clog2(COLS),
   localparam int YW          = $clog2(ROWS)
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          in_valid_i,
   input  logic [7:0]    in_ascii_i,
   output logic          in_ready_o,
   input  logic [XW-1:0] rd_x_i,
   input  logic [YW-1:0] rd_y_i,
   output logic [7:0]    rd_ascii_o,
   output logic [XW-1:0] cur_x_o,
   output logic [YW-1:0] cur_y_o
);

   localparam logic [XW-1:0] LAST_COL = XW'(COLS - 1);
   localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);
   localparam logic [XW:0]   COLS_W   = (XW + 1)'(COLS);
   localparam logic [YW:0]   ROWS_W   = (YW + 1)'(ROWS);
   localparam logic [7:0]    SPACE    = 8'h20;

   if (COLS < 2 || ROWS < 2 || BLINK_CYCLES < 1) begin : g_param_check
      $error("text_buffer: COLS and ROWS must be >= 2, BLINK_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      S_CLEAR_ALL,
      S_IDLE,
      S_CLEAR_ROW
   } state_t;

   state_t        state_q;
   logic [YW-1:0] top_q;
   logic [XW-1:0] cur_x_q;
   logic [YW-1:0] cur_y_q;
   logic [YW-1:0] clr_row_q;
   logic [XW-1:0] clr_col_q;
   logic          in_ready_q;
   logic [7:0]    rd_ascii_q;
   logic [7:0]    mem_q [ROWS][COLS];

   function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] top, input logic [YW-1:0] y);
      logic [YW:0] s;
      s = {1'b0, top} + {1'b0, y};
      if (s >= ROWS_W) s = s - ROWS_W;
      return s[YW-1:0];
   endfunction

   // Input decode; in_ready_q is only ever set while in S_IDLE
   logic          accept;
   logic          is_print;
   logic          is_nl;
   logic          is_bs;
   logic          do_nl;
   logic          do_scroll;
   logic          bs_ok;
   logic [XW-1:0] bs_x;
   logic [YW-1:0] bs_y;

   assign accept    = in_valid_i & in_ready_q;
   assign is_print  = (in_ascii_i >= 8'h20) && (in_ascii_i <= 8'h7E);
   assign is_nl     = (in_ascii_i == 8'h0A) || (in_ascii_i == 8'h0D);
   assign is_bs     = (in_ascii_i == 8'h08);
   assign do_nl     = accept & (is_nl | (is_print & (cur_x_q == LAST_COL)));
   assign do_scroll = do_nl & (cur_y_q == LAST_ROW);
   assign bs_ok     = accept & is_bs & ((cur_x_q != '0) | (cur_y_q != '0));
   assign bs_x      = (cur_x_q != '0) ? cur_x_q - XW'(1) : LAST_COL;
   assign bs_y      = (cur_x_q != '0) ? cur_y_q : cur_y_q - YW'(1);

   // Single write port shared by the clear sweeps and character handling
   logic          wr_en;
   logic [YW-1:0] wr_row;
   logic [XW-1:0] wr_col;
   logic [7:0]    wr_dat;

   always_comb begin
      wr_en  = 1'b0;
      wr_row = '0;
      wr_col = '0;
      wr_dat = SPACE;
      case (state_q)
         S_CLEAR_ALL, S_CLEAR_ROW: begin
            wr_en  = 1'b1;
            wr_row = clr_row_q;
            wr_col = clr_col_q;
         end
         S_IDLE: begin
            if (accept && is_print) begin
               wr_en  = 1'b1;
               wr_row = phys_row(top_q, cur_y_q);
               wr_col = cur_x_q;
               wr_dat = in_ascii_i;
            end else if (bs_ok) begin
               wr_en  = 1'b1;
               wr_row = phys_row(top_q, bs_y);
               wr_col = bs_x;
            end
         end
         default: wr_en = 1'b0;
      endcase
      if (reset_i) wr_en = 1'b0;
   end

   always_ff @(posedge clock_i) begin
      if (wr_en) mem_q[wr_row][wr_col] <= wr_dat;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= S_CLEAR_ALL;
         top_q      <= '0;
         cur_x_q    <= '0;
         cur_y_q    <= '0;
         clr_row_q  <= '0;
         clr_col_q  <= '0;
         in_ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR_ALL: begin
               if (clr_col_q == LAST_COL) begin
                  clr_col_q <= '0;
                  if (clr_row_q == LAST_ROW) begin
                     clr_row_q  <= '0;
                     state_q    <= S_IDLE;
                     in_ready_q <= 1'b1;
                  end else begin
                     clr_row_q <= clr_row_q + YW'(1);
                  end
               end else begin
                  clr_col_q <= clr_col_q + XW'(1);
               end
            end
            S_CLEAR_ROW: begin
               if (clr_col_q == LAST_COL) begin
                  clr_col_q  <= '0;
                  state_q    <= S_IDLE;
                  in_ready_q <= 1'b1;
               end else begin
                  clr_col_q <= clr_col_q + XW'(1);
               end
            end
            S_IDLE: begin
               if (do_scroll) begin
                  // The old top row becomes the new bottom row and is wiped
                  top_q      <= (top_q == LAST_ROW) ? '0 : top_q + YW'(1);
                  cur_x_q    <= '0;
                  clr_row_q  <= top_q;
                  clr_col_q  <= '0;
                  state_q    <= S_CLEAR_ROW;
                  in_ready_q <= 1'b0;
               end else if (do_nl) begin
                  cur_x_q <= '0;
                  cur_y_q <= cur_y_q + YW'(1);
               end else if (accept && is_print) begin
                  cur_x_q <= cur_x_q + XW'(1);
               end else if (bs_ok) begin
                  cur_x_q <= bs_x;
                  cur_y_q <= bs_y;
               end
            end
            default: begin
               state_q    <= S_CLEAR_ALL;
               clr_row_q  <= '0;
               clr_col_q  <= '0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   logic          rd_oob;
   logic [YW-1:0] rd_phys;
   logic [7:0]    rd_cell;
   logic [7:0]    rd_next;

   assign rd_oob  = ({1'b0, rd_x_i} >= COLS_W) || ({1'b0, rd_y_i} >= ROWS_W);
   assign rd_phys = phys_row(top_q, rd_y_i);
   assign rd_cell = rd_oob ? SPACE : mem_q[rd_phys][rd_x_i];

`ifdef TEXT_BUFFER_CURSOR_EN
   localparam int          BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

   logic [BW-1:0] blink_cnt_q;
   logic          blink_ph_q;

   always_ff @(posedge clock_i) begin
      if (reset_i || accept) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= ~blink_ph_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BW'(1);
      end
   end

   assign rd_next = (blink_ph_q && (rd_x_i == cur_x_q) && (rd_y_i == cur_y_q)) ? 8'h5F : rd_cell;
`else
   assign rd_next = rd_cell;
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i) rd_ascii_q <= 8'h00;
      else         rd_ascii_q <= rd_next;
   end

   assign in_ready_o = in_ready_q;
   assign rd_ascii_o = rd_ascii_q;
   assign cur_x_o    = cur_x_q;
   assign cur_y_o    = cur_y_q;

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer (COLS=4, ROWS=3): clear timing, printing, backspace, scrolling, reset abort.
module tb_text_buffer;

   localparam int COLS  = 4;
   localparam int ROWS  = 3;
   localparam int BLINK = 4;
   localparam int XW    = $clog2(COLS);
   localparam int YW    = $clog2(ROWS);

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_ascii;
   logic          in_ready;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic [7:0]    rd_ascii;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   text_buffer #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(BLINK)) dut (
      .clock_i   (clk),
      .reset_i   (reset),
      .in_valid_i(in_valid),
      .in_ascii_i(in_ascii),
      .in_ready_o(in_ready),
      .rd_x_i    (rd_x),
      .rd_y_i    (rd_y),
      .rd_ascii_o(rd_ascii),
      .cur_x_o   (cur_x),
      .cur_y_o   (cur_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cur(input string tag, input int x, input int y);
      chk({tag, "_x"}, 32'(cur_x), 32'(x));
      chk({tag, "_y"}, 32'(cur_y), 32'(y));
   endtask

   task automatic send(input logic [7:0] c);
      int n;
      in_valid = 1'b1;
      in_ascii = c;
      n = 0;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      chk($sformatf("send_ready_%02h", c), 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic rd(input int x, input int y, input logic [7:0] exp);
      rd_x = XW'(x);
      rd_y = YW'(y);
      exp_q.push_back(exp);
      step();
      chk($sformatf("rd_%0d_%0d", x, y), 32'(rd_ascii), 32'(exp_q.pop_front()));
   endtask

   task automatic rd_row(input int y, input string s);
      for (int x = 0; x < COLS; x++) rd(x, y, s[x]);
   endtask

   task automatic expect_busy(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk($sformatf("%s_busy%0d", tag, i), 32'(in_ready), 32'd0);
         step();
      end
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int hits;
      int plain;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_ascii = 8'h00;
      rd_x     = '0;
      rd_y     = '0;
      step();
      step();
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_rd", 32'(rd_ascii), 32'h00);
      chk_cur("rst_cur", 0, 0);
      reset = 1'b0;
      expect_busy("clr_all", ROWS * COLS);

      for (int y = 0; y < ROWS; y++) rd_row(y, "    ");
      rd(0, 3, 8'h20);
      rd(3, 3, 8'h20);

      send(8'h41);
      send(8'h42);
      chk_cur("ab", 2, 0);
      rd(0, 0, 8'h41);
      rd(1, 0, 8'h42);
      send(8'h07);
      chk_cur("bel", 2, 0);
      rd_row(0, "AB  ");

      send(8'h08);
      send(8'h08);
      chk_cur("bs2", 0, 0);
      rd_row(0, "    ");

      send_str("WXYZ");
      chk_cur("wxyz", 0, 1);
      rd(3, 0, 8'h5A);
      rd(0, 0, 8'h57);
      send(8'h08);
      chk_cur("bs_wrap", 3, 0);
      rd(3, 0, 8'h20);
      rd(2, 0, 8'h59);
      send_str("\010\010\010");
      chk_cur("bs3", 0, 0);
      send(8'h08);
      chk_cur("bs_origin", 0, 0);
      rd_row(0, "    ");

      send_str("AAAABBBBCC");
      chk_cur("fill", 2, 2);
      send(8'h0A);
      chk_cur("scroll1", 0, 2);
      expect_busy("scroll1", COLS);
      rd_row(0, "BBBB");
      rd_row(1, "CC  ");
      rd_row(2, "    ");

      send_str("DDDD");
      chk_cur("autowrap", 0, 2);
      expect_busy("autowrap", COLS);
      rd_row(0, "CC  ");
      rd_row(1, "DDDD");
      rd_row(2, "    ");

      send(8'h0D);
      chk_cur("cr_scroll", 0, 2);
      expect_busy("cr_scroll", COLS);
      rd_row(0, "DDDD");
      rd_row(1, "    ");

      send(8'h0A);
      step();
      chk("mid_clear_ready", 32'(in_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_cur("mid_rst", 0, 0);
      chk("mid_rst_rd", 32'(rd_ascii), 32'h00);
      expect_busy("mid_rst", ROWS * COLS);
      rd_row(0, "    ");
      rd_row(1, "    ");

      send(8'h51);
      chk_cur("blink_pos", 1, 0);
      rd(0, 0, 8'h51);
`ifdef TEXT_BUFFER_CURSOR_EN
      hits  = 0;
      plain = 0;
      rd_x  = XW'(1);
      rd_y  = YW'(0);
      for (int i = 0; i < 4 * BLINK; i++) begin
         step();
         if (rd_ascii == 8'h5F) hits++;
         else if (rd_ascii == 8'h20) plain++;
      end
      chk("blink_total", 32'(hits + plain), 32'(4 * BLINK));
      chk("blink_half", 32'(hits), 32'(2 * BLINK));
`else
      hits  = 0;
      plain = 0;
      for (int i = 0; i < 3 * BLINK; i++) rd(1, 0, 8'h20);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
